icache_line_state_ctrl: RTL and testbench
=========================================

// Module: icache_line_state_ctrl
// PURPOSE
// - Sequential, parametrised I-cache line-state controller. Owns the per-set, per-way I/C/D state array.
// - Applies CPU-access updates through a valid/ready handshake and reports the prior state and dirty status.
// - Adds a walking invalidate-all flush and a registered state-lookup port.
// - Sits between the I-cache tag/hit logic and the refill/writeback engine.
// PARAMETERS
// - SETS   64              number of cache sets, power of two, >=2
// - WAYS   2               ways per set, >=1
// - IDX_W  $clog2(SETS)    set-index width
// - WAY_W  max(1,$clog2(WAYS))  way-select width
// PORTS
// - clk              in   1        single clock; all logic on rising edge
// - reset            in   1        synchronous, active-high reset
// - req_valid        in   1        update request present
// - req_ready        out  1        controller can accept a request
// - req_index        in   IDX_W    target set
// - req_way          in   WAY_W    hit way on hit, victim way on miss
// - req_hit          in   1        lookup hit
// - req_write        in   1        0 = read, 1 = write
// - req_mem_fetch    in   1        miss is being filled from memory
// - rsp_valid        out  1        one-cycle response pulse
// - rsp_prev_state   out  2        state of (index,way) before the update
// - rsp_next_state   out  2        state written
// - rsp_is_dirty     out  1        rsp_prev_state == D
// - flush_start      in   1        request invalidate-all
// - flush_busy       out  1        flush walk in progress
// - flush_done       out  1        one-cycle pulse when the flush completes
// - lk_index         in   IDX_W    lookup set
// - lk_state         out  2*WAYS   registered states of lk_index; way w occupies [2w+1:2w]
// - dirty_count      out  CNT_W    only with ICACHE_DIRTY_COUNT_EN; CNT_W = $clog2(SETS*WAYS+1)
// BEHAVIOUR
// - Encoding: I=2'b10, C=2'b01, D=2'b00.
// - Reset (sync) values:
//   - whole array = I
//   - FSM = IDLE
//   - req_ready=1
//   - rsp_*=0
//   - flush_busy=0, flush_done=0
//   - lk_state = all-I
//   - dirty_count=0
// - FSM states: IDLE, UPD, FLUSH. req_ready = (state==IDLE) && !flush_start.
// - Accept (IDLE, req_valid & req_ready): capture the request fields; go to UPD.
// - UPD, one cycle:
//   - Read array[idx][way] as prev and compute next:
//     - hit & write   -> D
//     - hit & read    -> prev
//     - miss & fetch  -> C
//     - miss & !fetch -> I
//   - At the end of the cycle: write next to the array, register the rsp_* fields, set rsp_valid=1, return to IDLE.
// - Latency: accept edge -> rsp_valid high 2 cycles later, for exactly 1 cycle. Throughput: 1 request per 2 cycles.
// - Flush:
//   - flush_start sampled only in IDLE and wins over a same-cycle req_valid; that request is not accepted.
//   - In FLUSH, a counter walks sets 0..SETS-1 and writes all ways of one set to I per cycle; flush_busy=1.
//   - After set SETS-1: flush_done pulses 1 cycle, FSM returns to IDLE. Total SETS cycles busy.
//   - flush_start is ignored outside IDLE. Counter wrap is never reached; it clears on entry.
// - Lookup: lk_state <= array[lk_index] every cycle, write-first.
//   - A same-edge UPD or FLUSH write to lk_index is reflected in lk_state.
// - Reset during UPD or FLUSH aborts the operation: no rsp_valid/flush_done, array fully reset to I.
// CONFIGURATION
// - ICACHE_DIRTY_COUNT_EN defined:
//   - dirty_count port present.
//   - UPD: +1 on non-D -> D, -1 on D -> non-D, unchanged otherwise.
//   - Cleared to 0 on flush entry and on reset.
//   - Never exceeds SETS*WAYS.
// - Not defined: port and counter logic absent; all other behaviour identical.
// STRUCTURE
// - Package icache_state_pkg:
//   - I/C/D state localparams
//   - FSM state encoding (IDLE/UPD/FLUSH)
//   - function for the next-state table
// - Sub-module icache_next_state_fn:
//   - purely combinational (prev, hit, write, mem_fetch) -> (next, is_dirty)
//   - instantiated once in UPD
// - Array held in flops (SETS*WAYS*2 bits) so sync reset and the 1-set-per-cycle flush are direct.
// TESTING
// - Reset, then lk_index=5: lk_state all 2'b10; req_ready=1; dirty_count=0.
// - Miss+fetch idx3 way1, then read hit idx3 way1:
//   - responses prev=I/next=C, then prev=C/next=C
//   - rsp_valid 2 cycles after each accept
// - Write hit idx3 way1, then miss+fetch on the same line:
//   - next=D (dirty_count=1), then prev=D, rsp_is_dirty=1, next=C (dirty_count=0)
// - flush_start together with req_valid in IDLE:
//   - request not accepted; flush_busy for exactly SETS cycles; flush_done 1 pulse
//   - every lk_state afterwards = I; req then accepted
// - lk_index=7 held while UPD writes idx7 way0 -> D: lk_state[1:0] shows D on the same edge.
// - Assert reset mid-FLUSH and mid-UPD: no rsp_valid/flush_done pulse; all outputs at reset values next cycle.

Source files
------------

// File: rtl/icache_state_pkg.sv
// Shared encodings for the I-cache line-state controller: line states, controller FSM states
// and the line next-state table.
package icache_state_pkg;

   localparam logic [1:0] StateI = 2'b10;
   localparam logic [1:0] StateC = 2'b01;
   localparam logic [1:0] StateD = 2'b00;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StUpd   = 2'b01,
      StFlush = 2'b10
   } ctrl_state_e;

   // A hit keeps the line unless it is written; a miss either installs a clean copy or drops it.
   function automatic logic [1:0] line_next_state(input logic [1:0] prev,
                                                  input logic       hit,
                                                  input logic       write,
                                                  input logic       mem_fetch);
      logic [1:0] next;
      if (hit) begin
         next = write ? StateD : prev;
      end else begin
         next = mem_fetch ? StateC : StateI;
      end
      return next;
   endfunction

endpackage

// File: rtl/icache_next_state_fn.sv
// Combinational line-state update: maps the prior state and access type to the state to write
// back, and flags whether the prior state was dirty.
module icache_next_state_fn
   import icache_state_pkg::*;
(
   input  logic [1:0] prev,
   input  logic       hit,
   input  logic       write,
   input  logic       mem_fetch,
   output logic [1:0] next,
   output logic       is_dirty
);

   always_comb begin
      next     = line_next_state(prev, hit, write, mem_fetch);
      is_dirty = (prev == StateD);
   end

endmodule

// File: rtl/icache_line_state_ctrl.sv
// Per-set, per-way I/C/D state array with a handshaked update path, a walking invalidate-all
// flush and a registered write-first lookup port. ICACHE_DIRTY_COUNT_EN adds dirty_count.
module icache_line_state_ctrl
   import icache_state_pkg::*;
#(
   parameter int unsigned SETS  = 64,
   parameter int unsigned WAYS  = 2,
   parameter int unsigned IDX_W = $clog2(SETS),
   parameter int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
   parameter int unsigned CNT_W = $clog2(SETS * WAYS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [IDX_W-1:0]    req_index,
   input  logic [WAY_W-1:0]    req_way,
   input  logic                req_hit,
   input  logic                req_write,
   input  logic                req_mem_fetch,
   output logic                rsp_valid,
   output logic [1:0]          rsp_prev_state,
   output logic [1:0]          rsp_next_state,
   output logic                rsp_is_dirty,
   input  logic                flush_start,
   output logic                flush_busy,
   output logic                flush_done,
   input  logic [IDX_W-1:0]    lk_index,
   output logic [2*WAYS-1:0]   lk_state
`ifdef ICACHE_DIRTY_COUNT_EN
   ,
   output logic [CNT_W-1:0]    dirty_count
`endif
);

   localparam logic [2*WAYS-1:0]      SetAllI  = {WAYS{StateI}};
   localparam logic [2*SETS*WAYS-1:0] ArrAllI  = {(SETS * WAYS){StateI}};
   localparam logic [IDX_W-1:0]       LastSet  = IDX_W'(SETS - 1);

   ctrl_state_e state_q;

   logic [SETS-1:0][WAYS-1:0][1:0] arr_q, arr_d;

   logic [IDX_W-1:0] idx_q;
   logic [WAY_W-1:0] way_q;
   logic             hit_q;
   logic             write_q;
   logic             fetch_q;
   logic [IDX_W-1:0] flush_cnt_q;

   logic             way_ok;
   logic             upd_en;
   logic [1:0]       upd_prev;
   logic [1:0]       upd_next;
   logic             upd_is_dirty;

   assign req_ready = (state_q == StIdle) && !flush_start;

   // Way selects beyond WAYS (non-power-of-two configs) read as I and write nothing.
   assign way_ok   = (32'(way_q) < WAYS);
   assign upd_en   = (state_q == StUpd) && way_ok;
   assign upd_prev = way_ok ? arr_q[idx_q][way_q] : StateI;

   icache_next_state_fn u_next_state (
      .prev      (upd_prev),
      .hit       (hit_q),
      .write     (write_q),
      .mem_fetch (fetch_q),
      .next      (upd_next),
      .is_dirty  (upd_is_dirty)
   );

   always_comb begin
      arr_d = arr_q;
      if (upd_en) begin
         arr_d[idx_q][way_q] = upd_next;
      end else if (state_q == StFlush) begin
         arr_d[flush_cnt_q] = SetAllI;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         arr_q          <= ArrAllI;
         lk_state       <= SetAllI;
         idx_q          <= '0;
         way_q          <= '0;
         hit_q          <= 1'b0;
         write_q        <= 1'b0;
         fetch_q        <= 1'b0;
         flush_cnt_q    <= '0;
         rsp_valid      <= 1'b0;
         rsp_prev_state <= 2'b00;
         rsp_next_state <= 2'b00;
         rsp_is_dirty   <= 1'b0;
         flush_busy     <= 1'b0;
         flush_done     <= 1'b0;
      end else begin
         arr_q      <= arr_d;
         // Read from the next-state array so a same-edge write is visible immediately.
         lk_state   <= arr_d[lk_index];
         rsp_valid  <= 1'b0;
         flush_done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (flush_start) begin
                  state_q     <= StFlush;
                  flush_cnt_q <= '0;
                  flush_busy  <= 1'b1;
               end else if (req_valid) begin
                  state_q <= StUpd;
                  idx_q   <= req_index;
                  way_q   <= req_way;
                  hit_q   <= req_hit;
                  write_q <= req_write;
                  fetch_q <= req_mem_fetch;
               end
            end
            StUpd: begin
               state_q        <= StIdle;
               rsp_valid      <= 1'b1;
               rsp_prev_state <= upd_prev;
               rsp_next_state <= upd_next;
               rsp_is_dirty   <= upd_is_dirty;
            end
            StFlush: begin
               if (flush_cnt_q == LastSet) begin
                  state_q    <= StIdle;
                  flush_busy <= 1'b0;
                  flush_done <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q    <= StIdle;
               flush_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef ICACHE_DIRTY_COUNT_EN
   localparam logic [CNT_W-1:0] DirtyMax = CNT_W'(SETS * WAYS);

   logic [CNT_W-1:0] dirty_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         dirty_cnt_q <= '0;
      end else if ((state_q == StIdle) && flush_start) begin
         dirty_cnt_q <= '0;
      end else if (upd_en) begin
         if ((upd_prev != StateD) && (upd_next == StateD) && (dirty_cnt_q != DirtyMax)) begin
            dirty_cnt_q <= dirty_cnt_q + 1'b1;
         end else if ((upd_prev == StateD) && (upd_next != StateD) && (dirty_cnt_q != '0)) begin
            dirty_cnt_q <= dirty_cnt_q - 1'b1;
         end
      end
   end

   assign dirty_count = dirty_cnt_q;
`endif

endmodule

// File: tb/tb_icache_line_state_ctrl.sv
// Self-checking bench for icache_line_state_ctrl: directed vector table, randomized requests
// against an array model, and hand-written flush / reset-abort sequences.
module tb_icache_line_state_ctrl;

   localparam int SETS  = 64;
   localparam int WAYS  = 2;
   localparam int IDX_W = 6;
   localparam int WAY_W = 1;
   localparam int CNT_W = $clog2(SETS * WAYS + 1);

   localparam logic [1:0] LI = 2'b10;
   localparam logic [1:0] LC = 2'b01;
   localparam logic [1:0] LD = 2'b00;
   localparam logic [2*WAYS-1:0] ROW_I = {WAYS{2'b10}};

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [IDX_W-1:0]  req_index;
   logic [WAY_W-1:0]  req_way;
   logic              req_hit;
   logic              req_write;
   logic              req_mem_fetch;
   logic              rsp_valid;
   logic [1:0]        rsp_prev_state;
   logic [1:0]        rsp_next_state;
   logic              rsp_is_dirty;
   logic              flush_start;
   logic              flush_busy;
   logic              flush_done;
   logic [IDX_W-1:0]  lk_index;
   logic [2*WAYS-1:0] lk_state;
`ifdef ICACHE_DIRTY_COUNT_EN
   logic [CNT_W-1:0]  dirty_count;
`endif

   icache_line_state_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_index      (req_index),
      .req_way        (req_way),
      .req_hit        (req_hit),
      .req_write      (req_write),
      .req_mem_fetch  (req_mem_fetch),
      .rsp_valid      (rsp_valid),
      .rsp_prev_state (rsp_prev_state),
      .rsp_next_state (rsp_next_state),
      .rsp_is_dirty   (rsp_is_dirty),
      .flush_start    (flush_start),
      .flush_busy     (flush_busy),
      .flush_done     (flush_done),
      .lk_index       (lk_index),
      .lk_state       (lk_state)
`ifdef ICACHE_DIRTY_COUNT_EN
      ,
      .dirty_count    (dirty_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: plain array of line states.
   logic [1:0] mst [SETS][WAYS];

   typedef struct {
      int         idx;
      int         way;
      logic       hit;
      logic       wr;
      logic       fetch;
      logic [1:0] prev;
      logic [1:0] next;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] rule_next(input logic [1:0] prev, input logic hit,
                                            input logic wr, input logic fetch);
      if (hit && wr) return LD;
      if (hit) return prev;
      if (fetch) return LC;
      return LI;
   endfunction

   function automatic logic [2*WAYS-1:0] model_row(input int s);
      logic [2*WAYS-1:0] r;
      for (int w = 0; w < WAYS; w++) r[2*w +: 2] = mst[s][w];
      return r;
   endfunction

   function automatic int model_dirty();
      int n = 0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            if (mst[s][w] == LD) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mst[s][w] = LI;
   endtask

   task automatic do_req(input string tag, input int idx, input int way, input logic hit,
                         input logic wr, input logic fetch,
                         input logic [1:0] exp_prev, input logic [1:0] exp_next);
      req_index     = IDX_W'(idx);
      req_way       = WAY_W'(way);
      req_hit       = hit;
      req_write     = wr;
      req_mem_fetch = fetch;
      req_valid     = 1'b1;
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      check({tag, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
      step();
      mst[idx][way] = rule_next(mst[idx][way], hit, wr, fetch);
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " prev"}, 32'(rsp_prev_state), 32'(exp_prev));
      check({tag, " next"}, 32'(rsp_next_state), 32'(exp_next));
      check({tag, " dirty"}, 32'(rsp_is_dirty), 32'(exp_prev == LD));
      check({tag, " lk_state"}, 32'(lk_state), 32'(model_row(int'(lk_index))));
`ifdef ICACHE_DIRTY_COUNT_EN
      check({tag, " dirty_count"}, 32'(dirty_count), 32'(model_dirty()));
`endif
   endtask

   initial begin
      int busy, done, done_at, rsp_seen, bad, idx, way;
      logic hit, wr, fetch;

      vecs[0] = '{3, 1, 1'b0, 1'b0, 1'b1, LI, LC};
      vecs[1] = '{3, 1, 1'b1, 1'b0, 1'b0, LC, LC};
      vecs[2] = '{3, 1, 1'b1, 1'b1, 1'b0, LC, LD};
      vecs[3] = '{3, 1, 1'b0, 1'b0, 1'b1, LD, LC};
      vecs[4] = '{7, 0, 1'b1, 1'b1, 1'b0, LI, LD};
      vecs[5] = '{7, 0, 1'b0, 1'b0, 1'b0, LD, LI};
      vecs[6] = '{0, 0, 1'b0, 1'b1, 1'b1, LI, LC};
      vecs[7] = '{63, 1, 1'b1, 1'b1, 1'b0, LI, LD};
      vecs[8] = '{63, 1, 1'b1, 1'b0, 1'b1, LD, LD};

      reset = 1'b1; req_valid = 1'b0; req_index = '0; req_way = '0; req_hit = 1'b0;
      req_write = 1'b0; req_mem_fetch = 1'b0; flush_start = 1'b0; lk_index = IDX_W'(5);
      model_clear();
      step(); step(); step();
      reset = 1'b0;
      #1;
      check("reset lk_state", 32'(lk_state), 32'(ROW_I));
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset flush_busy", 32'(flush_busy), 32'd0);
      check("reset flush_done", 32'(flush_done), 32'd0);
`ifdef ICACHE_DIRTY_COUNT_EN
      check("reset dirty_count", 32'(dirty_count), 32'd0);
`endif

      for (int i = 0; i < 9; i++) begin
         lk_index = IDX_W'(vecs[i].idx);
         do_req($sformatf("vec%0d", i), vecs[i].idx, vecs[i].way, vecs[i].hit, vecs[i].wr,
                vecs[i].fetch, vecs[i].prev, vecs[i].next);
      end

      // Write-first lookup: idx7 way0 becomes D on the very edge it is written.
      lk_index = IDX_W'(7);
      do_req("wf", 7, 0, 1'b1, 1'b1, 1'b0, LI, LD);
      check("wf lk_state way0", 32'(lk_state[1:0]), 32'(LD));

      for (int n = 0; n < 150; n++) begin
         idx   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(7, 0))
                                              : int'($urandom_range(SETS - 1, 0));
         way   = int'($urandom_range(WAYS - 1, 0));
         hit   = 1'($urandom_range(1, 0));
         wr    = 1'($urandom_range(1, 0));
         fetch = 1'($urandom_range(1, 0));
         lk_index = IDX_W'($urandom_range(1, 0) == 1 ? idx : int'($urandom_range(SETS - 1, 0)));
         do_req($sformatf("rnd%0d", n), idx, way, hit, wr, fetch, mst[idx][way],
                rule_next(mst[idx][way], hit, wr, fetch));
      end

      // Flush wins over a same-cycle request.
      step();
      flush_start = 1'b1; req_valid = 1'b1; req_index = IDX_W'(9); req_way = '0;
      req_hit = 1'b1; req_write = 1'b1; req_mem_fetch = 1'b0;
      #1;
      check("flush req_ready", 32'(req_ready), 32'd0);
      step();
      flush_start = 1'b0; req_valid = 1'b0;
      busy = 0; done = 0; done_at = -1; rsp_seen = 0;
      for (int c = 0; c < SETS + 8; c++) begin
         flush_start = (c == 10);
         #1;
         if (c == 5) check("flush mid req_ready", 32'(req_ready), 32'd0);
         if (flush_busy) busy++;
         if (flush_done) begin
            done++;
            done_at = c;
         end
         if (rsp_valid) rsp_seen++;
         step();
      end
      flush_start = 1'b0;
      check("flush busy cycles", 32'(busy), 32'(SETS));
      check("flush done pulses", 32'(done), 32'd1);
      check("flush done time", 32'(done_at), 32'(SETS));
      check("flush no rsp", 32'(rsp_seen), 32'd0);
      bad = 0;
      for (int s = 0; s < SETS; s++) begin
         lk_index = IDX_W'(s);
         step();
         if (lk_state !== ROW_I) bad++;
      end
      check("flush sets not I", 32'(bad), 32'd0);
      model_clear();
`ifdef ICACHE_DIRTY_COUNT_EN
      check("flush dirty_count", 32'(dirty_count), 32'd0);
`endif
      lk_index = IDX_W'(9);
      do_req("post flush", 9, 0, 1'b1, 1'b1, 1'b0, LI, LD);
      do_req("post flush2", 12, 1, 1'b1, 1'b1, 1'b0, LI, LD);

      // Reset in the middle of a flush.
      flush_start = 1'b1;
      step();
      flush_start = 1'b0;
      step(); step(); step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("rst flush busy", 32'(flush_busy), 32'd0);
      check("rst flush done", 32'(flush_done), 32'd0);
      check("rst flush rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst flush req_ready", 32'(req_ready), 32'd1);
      check("rst flush lk_state", 32'(lk_state), 32'(ROW_I));
      model_clear();
      busy = 0; done = 0;
      for (int c = 0; c < SETS + 4; c++) begin
         if (flush_busy) busy++;
         if (flush_done) done++;
         step();
      end
      check("rst flush later busy", 32'(busy), 32'd0);
      check("rst flush later done", 32'(done), 32'd0);

      // Reset during the update cycle: no response, line stays I.
      do_req("pre upd", 5, 1, 1'b1, 1'b1, 1'b0, LI, LD);
      lk_index = IDX_W'(5);
      req_index = IDX_W'(5); req_way = '0; req_hit = 1'b1; req_write = 1'b1;
      req_mem_fetch = 1'b0; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("rst upd rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst upd req_ready", 32'(req_ready), 32'd1);
      check("rst upd lk_state", 32'(lk_state), 32'(ROW_I));
      step();
      model_clear();
      check("rst upd later rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst upd array", 32'(lk_state), 32'(ROW_I));
`ifdef ICACHE_DIRTY_COUNT_EN
      check("rst upd dirty_count", 32'(dirty_count), 32'd0);
`endif
      do_req("after rst", 5, 0, 1'b0, 1'b0, 1'b1, LI, LC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
